move_input_ctrl: RTL and testbench

- Conditions the two raw player push-buttons into clean `left`/`right` step requests for the ball/paddle position updater.
- Synchronises and debounces each button, resolves conflicting presses, and rate-limits movement.
- Emits one single-cycle step pulse on press, then auto-repeat pulses while held, so the updater moves exactly one pixel per pulse.
- Sits directly upstream of the position-update stage; its outputs drive that stage's `left`/`right` inputs.

---
 rtl/move_input_ctrl.sv | 136 +++++++++++++
 tb/tb_move_input_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/move_input_ctrl.sv
// Push-button conditioner: synchronises and debounces two raw buttons, then turns
// steady presses into single-cycle left/right step pulses with delayed auto-repeat.
module move_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned FIRST_DELAY     = 5000000,
    parameter int unsigned STEP_DIV        = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       left,
    output logic       right,
    output logic [1:0] dir
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RepMax = (FIRST_DELAY > STEP_DIV) ? FIRST_DELAY : STEP_DIV;
    localparam int unsigned RepW   = $clog2(RepMax) + 1;

    localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] FirstLast = RepW'(FIRST_DELAY - 1);
    localparam logic [RepW-1:0] StepLast  = RepW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StHoldL = 2'b01,
        StHoldR = 2'b10
    } state_e;

    // Bit 0 is the left button, bit 1 the right button.
    logic [1:0]     sync1_q;
    logic [1:0]     sync2_q;
    logic [1:0]     stable_q;
    logic [1:0]     stable_d;
    logic [DbW-1:0] db_cnt_q [2];
    logic [DbW-1:0] db_cnt_d [2];

    state_e          state_q;
    state_e          state_d;
    state_e          target;
    logic [RepW-1:0] rep_cnt_q;
    logic [RepW-1:0] rep_cnt_d;
    logic            rep_phase_q;
    logic            rep_phase_d;
    logic            left_q;
    logic            left_d;
    logic            right_q;
    logic            right_d;

    logic sl;
    logic sr;

    assign sl = stable_q[0];
    assign sr = stable_q[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d     = StIdle;
        target      = StIdle;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        left_d      = 1'b0;
        right_d     = 1'b0;

        if (sl && !sr) begin
            target = StHoldL;
        end else if (sr && !sl) begin
            target = StHoldR;
        end

        // Disabled forces idle regardless of buttons; releasing also drops pending repeats.
        if (enable && (target != StIdle)) begin
            state_d = target;
            if (target != state_q) begin
                left_d  = (target == StHoldL);
                right_d = (target == StHoldR);
            end else begin
                rep_phase_d = rep_phase_q;
                rep_cnt_d   = rep_cnt_q + RepW'(1);
                if ((!rep_phase_q && (rep_cnt_q == FirstLast)) ||
                    (rep_phase_q && (rep_cnt_q == StepLast))) begin
                    left_d      = (target == StHoldL);
                    right_d     = (target == StHoldR);
                    rep_cnt_d   = '0;
                    rep_phase_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            state_q     <= StIdle;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
        end else begin
            sync1_q     <= {btn_right, btn_left};
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            state_q     <= state_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            left_q      <= left_d;
            right_q     <= right_d;
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign dir   = state_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl: per-cycle expected {left,right,dir} values are
// queued per scenario and popped against the DUT one cycle at a time.
module tb_move_input_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned FD = 10;
    localparam int unsigned SD = 3;
    localparam int          MAXC = 128;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       left;
    logic       right;
    logic [1:0] dir;

    logic [3:0] sb_q[$];
    logic       exp_l   [1:MAXC];
    logic       exp_r   [1:MAXC];
    logic [1:0] exp_dir [1:MAXC];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    string      tag = "";

    move_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .FIRST_DELAY    (FD),
        .STEP_DIV       (SD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .left     (left),
        .right    (right),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    task automatic start_scenario(input string name);
        tag = name;
        cyc = 0;
        for (int c = 1; c <= MAXC; c++) begin
            exp_l[c]   = 1'b0;
            exp_r[c]   = 1'b0;
            exp_dir[c] = 2'b00;
        end
    endtask

    // Hold state occupies cycles entry..last: entry pulse, then FD, then every SD.
    task automatic plan_hold(input int entry, input int last, input bit is_r);
        int k;
        for (int c = entry; c <= last; c++) exp_dir[c] = is_r ? 2'b10 : 2'b01;
        k = entry;
        while (k <= last) begin
            if (is_r) exp_r[k] = 1'b1;
            else      exp_l[k] = 1'b1;
            k += (k == entry) ? FD : SD;
        end
    endtask

    task automatic plan_push(input int n);
        for (int c = 1; c <= n; c++) sb_q.push_back({exp_l[c], exp_r[c], exp_dir[c]});
    endtask

    task automatic check_now(input string name, input logic [3:0] expv);
        logic [3:0] got;
        got = {left, right, dir};
        n_cmp++;
        assert (got === expv) else begin
            n_bad++;
            $error("FAIL %s: got {l,r,dir}=%b expected %b", name, got, expv);
        end
    endtask

    task automatic run(input int n);
        logic [3:0] expv;
        logic [3:0] got;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s cycle %0d: scoreboard empty, got {l,r,dir}=%b", tag, cyc,
                         {left, right, dir});
            end else begin
                expv = sb_q.pop_front();
                got  = {left, right, dir};
                n_cmp++;
                assert (got === expv) else begin
                    n_bad++;
                    $error("FAIL %s cycle %0d: got {l,r,dir}=%b expected %b", tag, cyc, got,
                           expv);
                end
            end
        end
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1 check_now("reset_async_initial", 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        start_scenario("idle_after_reset");
        plan_push(20);
        run(20);

        // Mid-cycle reset with buttons idle.
        #3 reset = 1'b1;
        #1 check_now("reset_mid_cycle_idle", 4'b0000);
        @(posedge clk);
        #1 reset = 1'b0;
        start_scenario("idle_after_mid_reset");
        plan_push(20);
        run(20);

        // 3-cycle glitch is shorter than the debounce window.
        start_scenario("glitch_reject");
        plan_push(33);
        btn_left = 1'b1;
        run(3);
        btn_left = 1'b0;
        run(30);

        start_scenario("hold_left");
        plan_hold(7, 46, 1'b0);
        plan_push(70);
        btn_left = 1'b1;
        run(40);
        btn_left = 1'b0;
        run(30);

        start_scenario("both_then_left");
        plan_hold(37, 51, 1'b0);
        plan_push(60);
        btn_left  = 1'b1;
        btn_right = 1'b1;
        run(30);
        btn_right = 1'b0;
        run(15);
        btn_left = 1'b0;
        run(15);

        start_scenario("direct_switch");
        plan_hold(7, 30, 1'b0);
        plan_hold(31, 51, 1'b1);
        plan_push(60);
        btn_left = 1'b1;
        run(24);
        btn_left  = 1'b0;
        btn_right = 1'b1;
        run(21);
        btn_right = 1'b0;
        run(15);

        start_scenario("enable_toggle");
        plan_hold(7, 21, 1'b0);
        plan_hold(26, 46, 1'b0);
        plan_push(55);
        btn_left = 1'b1;
        run(21);
        enable = 1'b0;
        run(4);
        enable = 1'b1;
        run(15);
        btn_left = 1'b0;
        run(15);

        start_scenario("reset_mid_hold_pre");
        plan_hold(7, 18, 1'b0);
        plan_push(18);
        btn_left = 1'b1;
        run(18);
        #2 reset = 1'b1;
        #1 check_now("reset_mid_hold_async", 4'b0000);
        @(posedge clk);
        #1 check_now("reset_mid_hold_held", 4'b0000);
        reset = 1'b0;
        start_scenario("reset_mid_hold_post");
        plan_hold(7, 26, 1'b0);
        plan_push(35);
        run(20);
        btn_left = 1'b0;
        run(15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
